// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, control bundle
// and the stall/flush priority resolution used in RUN and on a MEMWAIT release.
package hazard_unit_pkg;

    typedef enum logic [1:0] {RUN, MEMWAIT, HALTED} hazard_state_t;

    localparam logic [1:0] REGSEL_LOAD = 2'b11;

    typedef struct packed {
        logic pc_en;
        logic en_fd;
        logic en_de;
        logic en_em;
        logic en_mw;
        logic flush_fd;
        logic flush_de;
        logic flush_em;
    } hazard_ctl_t;

    localparam hazard_ctl_t CTL_HOLD  = hazard_ctl_t'(8'b00000_000);
    localparam hazard_ctl_t CTL_RESET = hazard_ctl_t'(8'b00000_111);
    localparam hazard_ctl_t CTL_GO    = hazard_ctl_t'(8'b11111_000);

    // Branch flush outranks the load-use bubble: the hazarding DE instruction is squashed anyway.
    function automatic hazard_ctl_t resolve_ctl(input logic brtaken, input logic bubble,
                                                input logic ihit, input logic jump);
        hazard_ctl_t c;
        c = CTL_GO;
        if (brtaken) begin
            c.flush_fd = 1'b1;
            c.flush_de = 1'b1;
        end else if (bubble || !ihit) begin
            c.pc_en    = 1'b0;
            c.en_fd    = 1'b0;
            c.flush_de = 1'b1;
        end else if (jump) begin
            c.flush_fd = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard controller bundle: decode/execute hazard inputs and latch/PC controls.
interface hazard_unit_if #(parameter int CNT_W = 16);
    logic             ihit, dhit;
    logic [4:0]       rs_de, rt_de;
    logic             usesRt_de, jr_de, jump_de;
    logic             brtaken_ex;
    logic             regWr_ex;
    logic [4:0]       regDst_ex;
    logic [1:0]       regSel_ex;
    logic             dREN_ex;
    logic             dREN_me, dWEN_me;
    logic             halt_wb;
    logic             pc_en, en_fd, en_de, en_em, en_mw;
    logic             flush_fd, flush_de, flush_em;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport hu (
        input  ihit, dhit, rs_de, rt_de, usesRt_de, jr_de, jump_de, brtaken_ex,
               regWr_ex, regDst_ex, regSel_ex, dREN_ex, dREN_me, dWEN_me, halt_wb,
        output pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em,
               halted, stall_cnt, flush_cnt
    );

    modport tb (
        output ihit, dhit, rs_de, rt_de, usesRt_de, jr_de, jump_de, brtaken_ex,
               regWr_ex, regDst_ex, regSel_ex, dREN_ex, dREN_me, dWEN_me, halt_wb,
        input  pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em,
               halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter for performance debug; holds at all-ones instead of wrapping.
module sat_counter #(parameter int W = 16) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the five-stage pipeline: load-use and JR-after-load
// bubbles, memory wait states, control-flow flushes and halt.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic       CLK,
    input logic       RST,
    hazard_unit_if.hu hif
);
    hazard_state_t state_q, state_d;
    hazard_ctl_t   ctl;
    logic          halted_o;
    logic          dmem_miss, prod_ok, lu_haz, jr_haz;
    logic          stall_inc, flush_inc;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    assign dmem_miss = (hif.dREN_me | hif.dWEN_me) & ~hif.dhit;
    assign prod_ok   = hif.regWr_ex & (hif.regDst_ex != 5'd0);
    assign lu_haz    = prod_ok & hif.dREN_ex &
                       ((hif.regDst_ex == hif.rs_de) |
                        (hif.usesRt_de & (hif.regDst_ex == hif.rt_de)));
    assign jr_haz    = hif.jr_de & prod_ok & (hif.regSel_ex == REGSEL_LOAD) &
                       (hif.regDst_ex == hif.rs_de);

    always_ff @(posedge CLK) begin
        if (RST) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (hif.halt_wb)   state_d = HALTED;
                else if (dmem_miss) state_d = MEMWAIT;
            end
            MEMWAIT: if (hif.dhit) state_d = RUN;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Halt and an outstanding data miss freeze everything; otherwise the shared priority chain decides.
    always_comb begin
        ctl      = CTL_HOLD;
        halted_o = 1'b0;
        if (RST) begin
            ctl = CTL_RESET;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!hif.halt_wb && !dmem_miss)
                        ctl = resolve_ctl(hif.brtaken_ex, lu_haz | jr_haz, hif.ihit, hif.jump_de);
                end
                MEMWAIT: begin
                    if (hif.dhit)
                        ctl = resolve_ctl(hif.brtaken_ex, lu_haz | jr_haz, hif.ihit, hif.jump_de);
                end
                HALTED:  halted_o = 1'b1;
                default: ctl = CTL_HOLD;
            endcase
        end
    end

    assign stall_inc = ~RST & ~ctl.pc_en & (state_q != HALTED);
    assign flush_inc = ~RST & ctl.flush_fd;

    sat_counter #(.W(CNT_W)) u_stall_cnt (.CLK(CLK), .RST(RST), .inc(stall_inc), .count(stall_cnt));
    sat_counter #(.W(CNT_W)) u_flush_cnt (.CLK(CLK), .RST(RST), .inc(flush_inc), .count(flush_cnt));

    assign hif.pc_en     = ctl.pc_en;
    assign hif.en_fd     = ctl.en_fd;
    assign hif.en_de     = ctl.en_de;
    assign hif.en_em     = ctl.en_em;
    assign hif.en_mw     = ctl.en_mw;
    assign hif.flush_fd  = ctl.flush_fd;
    assign hif.flush_de  = ctl.flush_de;
    assign hif.flush_em  = ctl.flush_em;
    assign hif.halted    = halted_o;
    assign hif.stall_cnt = stall_cnt;
    assign hif.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a 16-bit counter instance plus a 2-bit
// counter instance fed the same stimulus for the saturation case.
module tb_hazard_unit;
    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    hazard_unit_if #(.CNT_W(16)) hif ();
    hazard_unit_if #(.CNT_W(2))  sif ();

    hazard_unit #(.CNT_W(16)) dut   (.CLK(CLK), .RST(RST), .hif(hif));
    hazard_unit #(.CNT_W(2))  dut_s (.CLK(CLK), .RST(RST), .hif(sif));

    assign sif.ihit = hif.ihit;           assign sif.dhit = hif.dhit;
    assign sif.rs_de = hif.rs_de;         assign sif.rt_de = hif.rt_de;
    assign sif.usesRt_de = hif.usesRt_de; assign sif.jr_de = hif.jr_de;
    assign sif.jump_de = hif.jump_de;     assign sif.brtaken_ex = hif.brtaken_ex;
    assign sif.regWr_ex = hif.regWr_ex;   assign sif.regDst_ex = hif.regDst_ex;
    assign sif.regSel_ex = hif.regSel_ex; assign sif.dREN_ex = hif.dREN_ex;
    assign sif.dREN_me = hif.dREN_me;     assign sif.dWEN_me = hif.dWEN_me;
    assign sif.halt_wb = hif.halt_wb;

    // {pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em}
    logic [7:0] ctl;
    assign ctl = {hif.pc_en, hif.en_fd, hif.en_de, hif.en_em, hif.en_mw,
                  hif.flush_fd, hif.flush_de, hif.flush_em};

    localparam logic [7:0] C_RESET  = 8'b00000_111;
    localparam logic [7:0] C_HOLD   = 8'b00000_000;
    localparam logic [7:0] C_GO     = 8'b11111_000;
    localparam logic [7:0] C_BUBBLE = 8'b00111_010;
    localparam logic [7:0] C_BRANCH = 8'b11111_110;
    localparam logic [7:0] C_JUMP   = 8'b11111_100;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        hif.ihit = 1'b1;       hif.dhit = 1'b0;
        hif.rs_de = 5'd0;      hif.rt_de = 5'd0;
        hif.usesRt_de = 1'b0;  hif.jr_de = 1'b0;  hif.jump_de = 1'b0;
        hif.brtaken_ex = 1'b0; hif.regWr_ex = 1'b0;
        hif.regDst_ex = 5'd0;  hif.regSel_ex = 2'b00; hif.dREN_ex = 1'b0;
        hif.dREN_me = 1'b0;    hif.dWEN_me = 1'b0;    hif.halt_wb = 1'b0;
    endtask

    task automatic load_in_ex(input logic [4:0] dst);
        hif.regWr_ex = 1'b1; hif.dREN_ex = 1'b1;
        hif.regDst_ex = dst; hif.regSel_ex = 2'b11;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        #1;
        check_eq("reset_ctl", 32'(ctl), 32'(C_RESET));
        check_eq("reset_halted", 32'(hif.halted), 32'd0);
        tick();
        check_eq("reset_stall_cnt", 32'(hif.stall_cnt), 32'd0);
        check_eq("reset_flush_cnt", 32'(hif.flush_cnt), 32'd0);
        RST = 1'b0;
        #1;
        check_eq("run_idle", 32'(ctl), 32'(C_GO));
        tick();

        // Load-use on rs: one bubble, then free flow
        load_in_ex(5'd8); hif.rs_de = 5'd8;
        #1;
        check_eq("lu_rs_bubble", 32'(ctl), 32'(C_BUBBLE));
        tick();
        check_eq("lu_stall_cnt", 32'(hif.stall_cnt), 32'd1);
        idle(); hif.rs_de = 5'd8;
        #1;
        check_eq("lu_next_cycle", 32'(ctl), 32'(C_GO));
        tick();
        check_eq("lu_stall_cnt_hold", 32'(hif.stall_cnt), 32'd1);

        // rt only matters when used as a register operand
        load_in_ex(5'd9); hif.rs_de = 5'd3; hif.rt_de = 5'd9; hif.usesRt_de = 1'b0;
        #1;
        check_eq("lu_rt_unused", 32'(ctl), 32'(C_GO));
        hif.usesRt_de = 1'b1;
        #1;
        check_eq("lu_rt_used", 32'(ctl), 32'(C_BUBBLE));
        tick();
        check_eq("lu_rt_stall_cnt", 32'(hif.stall_cnt), 32'd2);

        // A load into $0 never stalls
        idle(); load_in_ex(5'd0); hif.rs_de = 5'd0;
        #1;
        check_eq("lu_reg0", 32'(ctl), 32'(C_GO));

        // JR after a producer in EX
        idle();
        hif.jr_de = 1'b1; hif.jump_de = 1'b1; hif.rs_de = 5'd31;
        hif.regWr_ex = 1'b1; hif.regDst_ex = 5'd31; hif.regSel_ex = 2'b00;
        #1;
        check_eq("jr_alu_no_stall", 32'(ctl), 32'(C_JUMP));
        hif.regSel_ex = 2'b11;
        #1;
        check_eq("jr_load_stall", 32'(ctl), 32'(C_BUBBLE));
        tick();
        check_eq("jr_stall_cnt", 32'(hif.stall_cnt), 32'd3);
        check_eq("jr_flush_cnt", 32'(hif.flush_cnt), 32'd0);

        // Data miss: 3 frozen cycles, release on dhit
        idle(); hif.dREN_me = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("dmiss_hold%0d", i), 32'(ctl), 32'(C_HOLD));
            tick();
        end
        hif.dhit = 1'b1;
        #1;
        check_eq("dmiss_release", 32'(ctl), 32'(C_GO));
        tick();
        idle();
        #1;
        check_eq("dmiss_back_run", 32'(ctl), 32'(C_GO));
        check_eq("dmiss_stall_cnt", 32'(hif.stall_cnt), 32'd6);

        // Taken branch with a simultaneous load-use
        load_in_ex(5'd8); hif.rs_de = 5'd8; hif.brtaken_ex = 1'b1;
        #1;
        check_eq("br_lu_ctl", 32'(ctl), 32'(C_BRANCH));
        tick();
        check_eq("br_flush_cnt", 32'(hif.flush_cnt), 32'd1);
        check_eq("br_stall_cnt", 32'(hif.stall_cnt), 32'd6);

        // Instruction miss
        idle(); hif.ihit = 1'b0;
        #1;
        check_eq("imiss_ctl", 32'(ctl), 32'(C_BUBBLE));
        tick();
        check_eq("imiss_stall_cnt", 32'(hif.stall_cnt), 32'd7);

        // Halt together with a data miss: halt wins
        idle(); hif.halt_wb = 1'b1; hif.dREN_me = 1'b1;
        #1;
        check_eq("halt_ctl", 32'(ctl), 32'(C_HOLD));
        tick();
        idle(); hif.brtaken_ex = 1'b1; hif.dhit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("halted_ctl%0d", i), 32'(ctl), 32'(C_HOLD));
            check_eq($sformatf("halted_flag%0d", i), 32'(hif.halted), 32'd1);
            tick();
        end
        check_eq("halted_stall_cnt", 32'(hif.stall_cnt), 32'd8);
        check_eq("halted_flush_cnt", 32'(hif.flush_cnt), 32'd1);

        // Reset pulse leaves HALTED
        idle(); RST = 1'b1;
        #1;
        check_eq("rst_halt_ctl", 32'(ctl), 32'(C_RESET));
        check_eq("rst_halt_flag", 32'(hif.halted), 32'd0);
        tick();
        RST = 1'b0;
        #1;
        check_eq("post_rst_ctl", 32'(ctl), 32'(C_GO));
        check_eq("post_rst_halted", 32'(hif.halted), 32'd0);
        check_eq("post_rst_stall_cnt", 32'(hif.stall_cnt), 32'd0);
        check_eq("post_rst_flush_cnt", 32'(hif.flush_cnt), 32'd0);

        // Reset while in MEMWAIT
        hif.dREN_me = 1'b1;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; idle();
        #1;
        check_eq("rst_memwait_ctl", 32'(ctl), 32'(C_GO));
        check_eq("rst_memwait_cnt", 32'(hif.stall_cnt), 32'd0);

        // Saturation on the 2-bit instance
        hif.ihit = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        idle();
        #1;
        check_eq("sat_small_stall", 32'(sif.stall_cnt), 32'd3);
        check_eq("sat_wide_stall", 32'(hif.stall_cnt), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline stall/flush controller for the five-stage MIPS pipeline (FE/DE/EX/ME/WB). It covers the hazards the forwarding network cannot resolve:
- a load in EX feeding the instruction in DE (there is no dmemload forwarding into EX, and JR forwarding cannot source an EX load);
- instruction and data memory wait states;
- control-flow flushes;
- halt.

It drives the enable and flush controls of the PC and of the four pipeline latches, and keeps saturating stall/flush counters for performance debug.

## Interface
- CNT_W, 16, width of the stall and flush performance counters
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- ihit  in  1  instruction memory returned this cycle
- dhit  in  1  data memory access completed this cycle
- rs_de, rt_de  in  5  source registers of the instruction in DE
- usesRt_de  in  1  DE instruction reads rt as a register operand
- jr_de  in  1  DE instruction is JR
- jump_de  in  1  J/JAL/JR redirect resolved in DE
- brtaken_ex  in  1  branch taken, resolved in EX
- regWr_ex, regDst_ex[4:0], regSel_ex[1:0], dREN_ex  in  writeback info of the EX instruction
- dREN_me, dWEN_me  in  1  MEM-stage data request
- halt_wb  in  1  HALT reached WB latch
- pc_en  out  1  PC update enable
- en_fd, en_de, en_em, en_mw  out  1  latch enables
- flush_fd, flush_de, flush_em  out  1  latch flushes (load a bubble)
- halted  out  1  sticky halt indication
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters

## Operation
- FSM states: RUN, MEMWAIT, HALTED.
- Definitions:
  - dmem_req = dREN_me | dWEN_me
  - prod_ok = regWr_ex & regDst_ex != 0
  - lu_haz = prod_ok & dREN_ex & (regDst_ex == rs_de | (usesRt_de & regDst_ex == rt_de))
  - jr_haz = jr_de & prod_ok & regSel_ex == REGSEL_LOAD & regDst_ex == rs_de
- Outputs are combinational from state and inputs; the state and counters are registered.
- RUN, rules applied in priority order (first match wins):
  1. halt_wb: all enables 0, next state HALTED.
  2. dmem_req & !dhit: all enables 0, PC held, next state MEMWAIT.
  3. brtaken_ex: all enables 1, flush_fd = flush_de = 1.
  4. lu_haz | jr_haz: pc_en = en_fd = 0, flush_de = 1, en_em = en_mw = 1. Exactly one bubble is inserted. Next cycle the load is in ME and the dependent instruction in DE; WB forwarding then covers the ALU use and ME forwarding covers JR.
  5. !ihit: pc_en = en_fd = 0, flush_de = 1, en_em = en_mw = 1.
  6. jump_de: all enables 1, flush_fd = 1.
  7. Otherwise: all enables 1, no flush.
- MEMWAIT: all enables 0 until dhit. In the dhit cycle, evaluate rules 3–7 as in RUN, then return to RUN.
- HALTED: all enables 0, no flushes, halted = 1. Only RST exits this state.
- A flush dominates the enable of the same latch: the latch loads a bubble.
- stall_cnt increments on any cycle with pc_en = 0 outside HALTED.
- flush_cnt increments on any cycle with flush_fd = 1.
- Both counters saturate at all-ones and do not wrap.

## Timing
- Zero-cycle decision latency: outputs respond in the same cycle as their inputs.
- State and counters update on the CLK rising edge.
- Reset:
  - while RST = 1: all en_* and pc_en = 0, flush_* = 1, halted = 0;
  - on the first edge with RST = 1: state RUN, stall_cnt = flush_cnt = 0.
- Reset mid-MEMWAIT or in HALTED returns to RUN on the next edge. Counters clear.
- brtaken_ex coinciding with lu_haz: the flush wins. The hazarding DE instruction is squashed, so no bubble stall is counted.
- halt_wb coinciding with a dmem miss: HALTED wins.
- A load whose destination register is 0 never stalls.

## Structure
- Add to cpu_types_pkg:
  - hazard_state_t enum {RUN, MEMWAIT, HALTED}
  - REGSEL_LOAD = 2'b11, alongside REGSEL_ALU/NPC/LUI
- Ports are grouped in hazard_unit_if with modport hu, matching the existing pipeline interfaces.
- One sub-module, sat_counter (parameter W; ports CLK, RST, inc, count), instantiated twice.

## Test plan
- Load-use: dREN_ex = 1, regDst_ex = 8, rs_de = 8, ihit = 1 → exactly one cycle of pc_en = 0, en_fd = 0, flush_de = 1; stall_cnt = 1; no stall the following cycle.
- JR after load: jr_de = 1, rs_de = 31, regDst_ex = 31, regSel_ex = 2'b11 → one stall cycle. With regSel_ex = 2'b00 → no stall.
- Dmem miss: dREN_me = 1, dhit = 0 for 3 cycles, then 1 → all enables 0 for 3 cycles in MEMWAIT; enables 1 in the dhit cycle; state RUN afterwards; stall_cnt = 3.
- Branch taken with a simultaneous load-use → flush_fd = flush_de = 1, pc_en = 1, flush_cnt = 1, stall_cnt unchanged.
- halt_wb = 1 → halted = 1 on the next cycle, all enables 0 indefinitely; RST pulse → RUN, counters 0, halted = 0.
- CNT_W = 2, 5 stall cycles → stall_cnt holds at 3.
